mem_stage_cache: RTL
====================

Name: mem_stage_cache

Overview:
- MEM-stage data-cache controller. It produces what the MEM/WB pipeline buffer consumes: cache_data_out_mem[0:3], byte_number_mem, the cache register_write flag, and the pipeline-wide lock (stall).
- Structure: direct-mapped, one 32-bit word per line, write-through, no write-allocate.
- Backed by a variable-latency main memory using a req/ready handshake.
- lock freezes every pipeline buffer while a miss or store is outstanding.

Parameters:
- NUM_LINES, 8: number of cache lines; power of two, at least 2. IDX_W = $clog2(NUM_LINES).
- TAG_W, 30-IDX_W: tag width, derived; do not override.

Ports:
- clk  in  1  clock.
- rst_b  in  1  asynchronous active-low reset.
- mem_addr_mem  in  32  byte address of the access.
- mem_read_mem  in  1  load request.
- mem_write_mem  in  1  store request.
- is_word_mem  in  1  1 = word access, 0 = byte access.
- mem_data_in_mem  in  8x[0:3]  store data; index i = byte at word address + i.
- cache_data_out_mem  out  8x[0:3]  loaded word; index i = byte at word address + i.
- byte_number_mem  out  2  mem_addr_mem[1:0], passed through combinationally.
- register_write  out  1  access completed in the current cycle (cache-side write qualifier).
- lock  out  1  stall request to all pipeline buffers.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write (qualified by mem_req).
- mem_be  out  4  byte enables; bit i = byte lane i.
- mem_word_addr  out  30  word address to memory.
- mem_wdata  out  8x[0:3]  memory write data.
- mem_rdata  in  8x[0:3]  memory read data.
- mem_ready  in  1  memory completes the request this cycle.

Behaviour:
- Address split: index = addr[IDX_W+1:2]; tag = addr[31:IDX_W+2].
- Hit: valid[index] && tag matches.
- Storage: per line, one valid bit, a tag, and 4 data bytes. rst_b clears all valid bits. Data and tag arrays need no reset.
- Precedence: if mem_read_mem and mem_write_mem are both high, the access is treated as a store.
- FSM states: IDLE, FILL, WRITE, RESP. Reset state is IDLE.
- IDLE, no request:
  - lock=0, register_write=0.
- IDLE, load hit:
  - cache_data_out_mem = line data, combinational.
  - lock=0, register_write=1, same cycle. Zero added latency.
- IDLE, load miss:
  - lock=1 combinationally.
  - Capture word address into a request register; go to FILL.
- IDLE, store:
  - lock=1.
  - Capture address, byte enables and data; go to WRITE.
  - Word store: be=1111, all lanes from mem_data_in_mem.
  - Byte store: be has only bit addr[1:0] set; lane addr[1:0] = mem_data_in_mem[addr[1:0]].
- FILL:
  - mem_req=1, mem_we=0, mem_word_addr = captured address; lock=1.
  - On mem_ready: write mem_rdata, tag and valid=1 into the line; go to RESP.
- WRITE:
  - mem_req=1, mem_we=1, with the captured be and data; lock=1.
  - On mem_ready: if the captured line hits, merge the enabled bytes into it (no allocate on miss); go to RESP.
- RESP:
  - lock=0, register_write=1.
  - cache_data_out_mem = line data; for a store that was not cached, outputs are don't-care.
  - No new request is issued even though the MEM-stage inputs are unchanged. Next state is IDLE.
- Miss latency: the stall lasts exactly N+1 cycles, where N = cycles from entering FILL/WRITE to mem_ready (N ≥ 1).
- mem_req holds high and all request fields stay stable until mem_ready. mem_ready outside FILL/WRITE is ignored.
- Reset asserted mid-operation:
  - Immediately returns to IDLE and drops mem_req, lock and register_write.
  - Clears valid bits; the pending request is discarded.
- Reset values of outputs: lock=0, register_write=0, mem_req=0, mem_we=0, mem_be=0, mem_word_addr=0, mem_wdata=0. cache_data_out_mem=0 while no valid hit.
- A store to the same word immediately followed by a load returns the merged data (the line is updated before RESP).

Optional Feature:
- Macro: MEM_STAGE_CACHE_STATS_EN.
- When defined, the block adds outputs hit_count[31:0] and miss_count[31:0].
  - hit_count increments on each IDLE load hit.
  - miss_count increments on each IDLE load miss.
  - Both counters saturate at 32'hFFFF_FFFF and reset to 0.
- When not defined, these ports and the counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset, then a load to 0x0000_0040 with memory ready after 3 cycles → lock high 4 cycles; mem_word_addr=0x10; then RESP with cache_data_out=mem_rdata and register_write=1.
- Repeat the load to 0x40 → hit: lock=0 and register_write=1 in the same cycle, data unchanged, mem_req never asserted.
- Byte store of 0xAB to 0x42 after the line is filled with 11 22 33 44 → mem_be=0100, lane 2=0xAB. A following load of 0x40 hits and returns 11 22 AB 44.
- Load 0x40, then load 0x40+4*NUM_LINES (same index, different tag) → second access misses and refills. A third load of 0x40 misses again.
- rst_b pulsed low during FILL → mem_req and lock fall asynchronously; after release, a load of 0x40 misses.
- mem_read_mem and mem_write_mem both high → store path taken (mem_we=1). With MEM_STAGE_CACHE_STATS_EN, miss_count is unchanged by this access.

Source files
------------

// File: rtl/mem_stage_cache.sv
// MEM-stage data cache: direct-mapped, one word per line, write-through, no write-allocate.
// Optional hit/miss counters are built when MEM_STAGE_CACHE_STATS_EN is defined.
module mem_stage_cache #(
    parameter int NUM_LINES = 8
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic [31:0] mem_addr_mem,
    input  logic        mem_read_mem,
    input  logic        mem_write_mem,
    input  logic        is_word_mem,
    input  logic [7:0]  mem_data_in_mem [0:3],
    output logic [7:0]  cache_data_out_mem [0:3],
    output logic [1:0]  byte_number_mem,
    output logic        register_write,
    output logic        lock,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [29:0] mem_word_addr,
    output logic [7:0]  mem_wdata [0:3],
    input  logic [7:0]  mem_rdata [0:3],
    input  logic        mem_ready
`ifdef MEM_STAGE_CACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [29:0]          req_addr_q, req_addr_d;
    logic [3:0]           req_be_q, req_be_d;
    logic [31:0]          req_wdata_q, req_wdata_d;
    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_q [NUM_LINES];
    logic [31:0]          data_q [NUM_LINES];

    logic [IDX_W-1:0]     in_idx_s, req_idx_s, out_idx_s;
    logic [TAG_W-1:0]     in_tag_s, req_tag_s;
    logic                 in_hit_s, req_hit_s, out_hit_s;
    logic                 is_store_s, is_load_s;
    logic                 line_we_s, valid_set_s;
    logic [31:0]          line_wdata_s, in_wdata_s, rdata_s, out_word_s;
    logic [3:0]           in_be_s;
    logic                 lock_s, reg_write_s;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        end
        return res;
    endfunction

    assign in_idx_s   = mem_addr_mem[IDX_W+1:2];
    assign in_tag_s   = mem_addr_mem[31:IDX_W+2];
    assign req_idx_s  = req_addr_q[IDX_W-1:0];
    assign req_tag_s  = req_addr_q[29:IDX_W];
    assign in_hit_s   = valid_q[in_idx_s] && (tag_q[in_idx_s] == in_tag_s);
    assign req_hit_s  = valid_q[req_idx_s] && (tag_q[req_idx_s] == req_tag_s);
    assign is_store_s = mem_write_mem;
    assign is_load_s  = mem_read_mem && !mem_write_mem;
    assign in_be_s    = is_word_mem ? 4'b1111 : (4'b0001 << mem_addr_mem[1:0]);

    // Pack byte lanes; a byte store only carries the addressed lane.
    always_comb begin
        in_wdata_s = 32'h0000_0000;
        rdata_s    = 32'h0000_0000;
        for (int i = 0; i < 4; i++) begin
            rdata_s[8*i +: 8] = mem_rdata[i];
            if (is_word_mem || (mem_addr_mem[1:0] == 2'(i))) begin
                in_wdata_s[8*i +: 8] = mem_data_in_mem[i];
            end else begin
                in_wdata_s[8*i +: 8] = 8'h00;
            end
        end
    end

    // Next-state, request capture and line-update decisions.
    always_comb begin
        state_d      = state_q;
        req_addr_d   = req_addr_q;
        req_be_d     = req_be_q;
        req_wdata_d  = req_wdata_q;
        line_we_s    = 1'b0;
        valid_set_s  = 1'b0;
        line_wdata_s = data_q[req_idx_s];
        lock_s       = 1'b0;
        reg_write_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_store_s) begin
                    lock_s      = 1'b1;
                    req_addr_d  = mem_addr_mem[31:2];
                    req_be_d    = in_be_s;
                    req_wdata_d = in_wdata_s;
                    state_d     = WRITE;
                end else if (is_load_s && in_hit_s) begin
                    reg_write_s = 1'b1;
                end else if (is_load_s) begin
                    lock_s     = 1'b1;
                    req_addr_d = mem_addr_mem[31:2];
                    state_d    = FILL;
                end else begin
                    state_d = IDLE;
                end
            end
            FILL: begin
                lock_s = 1'b1;
                if (mem_ready) begin
                    line_we_s    = 1'b1;
                    valid_set_s  = 1'b1;
                    line_wdata_s = rdata_s;
                    state_d      = RESP;
                end else begin
                    state_d = FILL;
                end
            end
            WRITE: begin
                lock_s = 1'b1;
                if (mem_ready) begin
                    // No allocate: only a line already holding this word is merged.
                    line_we_s    = req_hit_s;
                    line_wdata_s = merge_bytes(data_q[req_idx_s], req_wdata_q, req_be_q);
                    state_d      = RESP;
                end else begin
                    state_d = WRITE;
                end
            end
            RESP: begin
                reg_write_s = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state, request registers and valid bits.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= IDLE;
            req_addr_q  <= 30'h0;
            req_be_q    <= 4'h0;
            req_wdata_q <= 32'h0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            req_addr_q  <= req_addr_d;
            req_be_q    <= req_be_d;
            req_wdata_q <= req_wdata_d;
            if (valid_set_s) begin
                valid_q[req_idx_s] <= 1'b1;
            end
        end
    end

    // Tag and data arrays hold no reset; valid bits qualify them.
    always_ff @(posedge clk) begin
        if (line_we_s) begin
            tag_q[req_idx_s]  <= req_tag_s;
            data_q[req_idx_s] <= line_wdata_s;
        end
    end

    // Read port: live address in IDLE, captured address while responding.
    always_comb begin
        out_idx_s = in_idx_s;
        out_hit_s = 1'b0;
        if (state_q == IDLE) begin
            out_hit_s = in_hit_s;
        end else if (state_q == RESP) begin
            out_idx_s = req_idx_s;
            out_hit_s = req_hit_s;
        end else begin
            out_hit_s = 1'b0;
        end
        out_word_s = out_hit_s ? data_q[out_idx_s] : 32'h0000_0000;
        for (int i = 0; i < 4; i++) begin
            cache_data_out_mem[i] = out_word_s[8*i +: 8];
            mem_wdata[i]          = req_wdata_q[8*i +: 8];
        end
    end

    assign byte_number_mem = mem_addr_mem[1:0];
    assign lock            = lock_s && rst_b;
    assign register_write  = reg_write_s && rst_b;
    assign mem_req         = (state_q == FILL) || (state_q == WRITE);
    assign mem_we          = (state_q == WRITE);
    assign mem_be          = req_be_q;
    assign mem_word_addr   = req_addr_q;

`ifdef MEM_STAGE_CACHE_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

    // Saturating counters of IDLE-state load lookups.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if ((state_q == IDLE) && is_load_s && in_hit_s && (hit_cnt_q != 32'hFFFF_FFFF)) begin
            hit_cnt_d = hit_cnt_q + 32'd1;
        end else begin
            hit_cnt_d = hit_cnt_q;
        end
        if ((state_q == IDLE) && is_load_s && !in_hit_s && (miss_cnt_q != 32'hFFFF_FFFF)) begin
            miss_cnt_d = miss_cnt_q + 32'd1;
        end else begin
            miss_cnt_d = miss_cnt_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            hit_cnt_q  <= 32'h0;
            miss_cnt_q <= 32'h0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule
